// File: rtl/l2_playback_pkg.sv
// l2_playback_pkg: shared states, default widths, L2 bus bit positions and helpers
package l2_playback_pkg;
  localparam int L2_IN_W = 170;
  localparam int L2_OUT_W = 71;
  localparam int L2_RSTN_BIT = 169;
  localparam int NOC2_VALID_BIT = 64;
  localparam int NOC2_DATA_LSB = 0;
  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN, S_DONE} state_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/l2_playback_vec_ram.sv
// l2_playback_vec_ram: simple dual-port vector memory with registered, enable-held read
module l2_playback_vec_ram import l2_playback_pkg::*; #(
  parameter int W = L2_IN_W + 2 * L2_OUT_W,
  parameter int DEPTH = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/l2_playback_sequencer.sv
// l2_playback_sequencer: replays stored stimulus onto the L2 inputs and checks masked responses
module l2_playback_sequencer import l2_playback_pkg::*; #(
  parameter int IN_W = L2_IN_W,
  parameter int OUT_W = L2_OUT_W,
  parameter int DEPTH = 1024,
  parameter int ADDR_W = 10,
  parameter int CMP_LAG = 1,
  parameter int STOP_ON_ERR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [IN_W-1:0]   wr_in,
  input  logic [OUT_W-1:0]  wr_exp,
  input  logic [OUT_W-1:0]  wr_mask,
  input  logic              start,
  input  logic [ADDR_W:0]   num_vec,
  input  logic              hold,
  input  logic              abort,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] fail_idx,
  output logic [OUT_W-1:0]  fail_got
);
  localparam int W = IN_W + 2 * OUT_W;
  localparam int PW = 1 + 2 * OUT_W + ADDR_W;
  localparam logic [ADDR_W:0] MAX_N = (ADDR_W + 1)'(DEPTH);
  localparam logic [1:0] LAST_D = 2'(CMP_LAG - 1);
  localparam logic STOP = STOP_ON_ERR != 0;
  state_t state, state_n;
  logic [ADDR_W:0] n_vec, cnt, cnt_p1, n_clamp;
  logic [1:0] dcnt;
  logic [PW-1:0] pipe [CMP_LAG];
  logic [PW-1:0] tail;
  logic [W-1:0] rdata;
  logic [ADDR_W-1:0] raddr;
  logic adv, mism, step, go, re;
  l2_playback_vec_ram #(.W(W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .we(wr_en && !busy),
    .waddr(wr_addr),
    .wdata({wr_in, wr_exp, wr_mask}),
    .re(re),
    .raddr(raddr),
    .rdata(rdata)
  );
  assign busy = state == S_PRIME || state == S_RUN || state == S_DRAIN;
  assign done = state == S_DONE;
  assign pass = done && err_cnt == 16'd0;
  assign cnt_p1 = cnt + 1'b1;
  assign n_clamp = (num_vec > MAX_N) ? MAX_N : num_vec;
  assign tail = pipe[CMP_LAG-1];
  assign adv = (state == S_RUN || state == S_DRAIN) && !hold;
  assign mism = adv && tail[PW-1] && |((dut_out ^ tail[PW-2 -: OUT_W]) & tail[ADDR_W +: OUT_W]);
  assign step = state == S_RUN && !hold && !(mism && STOP);
  assign go = start && !abort && (state == S_IDLE || state == S_DONE);
  assign re = state == S_PRIME || step;
  assign raddr = (state == S_PRIME) ? '0 : cnt_p1[ADDR_W-1:0];
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: state_n = !start ? state : (n_clamp == '0) ? S_DONE : S_PRIME;
      S_PRIME: state_n = S_RUN;
      S_RUN: state_n = (mism && STOP) ? S_DONE : (step && cnt_p1 == n_vec) ? S_DRAIN : S_RUN;
      S_DRAIN: state_n = ((mism && STOP) || (!hold && dcnt == LAST_D)) ? S_DONE : S_DRAIN;
      default: state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      dut_in <= '0;
      n_vec <= '0;
      cnt <= '0;
      dcnt <= '0;
      err_cnt <= '0;
      fail_idx <= '0;
      fail_got <= '0;
      for (int j = 0; j < CMP_LAG; j++) pipe[j] <= '0;
    end else begin
      state <= state_n;
      if (abort) dut_in <= '0;
      else if (step) dut_in <= rdata[W-1 -: IN_W];
      if (abort || go) begin
        n_vec <= n_clamp;
        cnt <= '0;
        dcnt <= '0;
        err_cnt <= '0;
        fail_idx <= '0;
        fail_got <= '0;
        for (int j = 0; j < CMP_LAG; j++) pipe[j] <= '0;
      end else begin
        if (step) cnt <= cnt_p1;
        if (state == S_DRAIN && !hold) dcnt <= dcnt + 2'd1;
        if (adv) begin
          for (int j = CMP_LAG - 1; j > 0; j--) pipe[j] <= pipe[j-1];
          pipe[0] <= {step, rdata[2*OUT_W-1:0], cnt[ADDR_W-1:0]};
        end
        if (mism) begin
          err_cnt <= sat_inc(err_cnt);
          if (err_cnt == 16'd0) begin
            fail_idx <= tail[ADDR_W-1:0];
            fail_got <= dut_out;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_l2_playback_sequencer.sv
// tb_l2_playback_sequencer: scoreboard bench with a loopback L2 model on two sequencer instances
module tb_l2_playback_sequencer;
  typedef struct {
    string name;
    logic pass;
    logic [15:0] err;
    logic [9:0] fidx;
    logic [70:0] fgot;
    logic [169:0] din;
    int cyc;
  } exp_t;
  logic clk, rst, wr_en, start, start_c, hold, abort;
  logic [9:0] wr_addr;
  logic [169:0] wr_in;
  logic [70:0] wr_exp, wr_mask;
  logic [10:0] num_vec;
  logic [169:0] dut_in, dut_in_c;
  logic [70:0] dut_out, dut_out_c, fail_got, fail_got_c;
  logic busy, done, pass, busy_c, done_c, pass_c;
  logic [15:0] err_cnt, err_cnt_c;
  logic [9:0] fail_idx, fail_idx_c;
  exp_t qd[$], qc[$];
  int n_chk, n_fail, cyc_d, cyc_c;
  logic dq_d, dq_c;
  function automatic logic [70:0] f(input logic [169:0] x);
    return x[70:0] ^ x[169:99];
  endfunction
  function automatic logic [169:0] mk(input int i);
    logic [31:0] w;
    w = 32'hA5C3_0000 ^ (i * 32'h0101_0101);
    return {1'b1, {5{w}}, w[8:0]};
  endfunction
  assign dut_out = f(dut_in);
  assign dut_out_c = f(dut_in_c);
  l2_playback_sequencer #(.STOP_ON_ERR(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_in(wr_in), .wr_exp(wr_exp),
    .wr_mask(wr_mask), .start(start), .num_vec(num_vec), .hold(hold), .abort(abort),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_idx(fail_idx), .fail_got(fail_got)
  );
  l2_playback_sequencer #(.STOP_ON_ERR(0)) dut_c (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_in(wr_in), .wr_exp(wr_exp),
    .wr_mask(wr_mask), .start(start_c), .num_vec(num_vec), .hold(1'b0), .abort(1'b0),
    .dut_in(dut_in_c), .dut_out(dut_out_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_cnt(err_cnt_c), .fail_idx(fail_idx_c), .fail_got(fail_got_c)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic cmp(input string nm, input logic [169:0] got, input logic [169:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask
  task automatic verify(input exp_t e, input logic p, input logic [15:0] ec, input logic [9:0] fi,
                        input logic [70:0] fg, input logic [169:0] di, input int cy);
    cmp({e.name, ".pass"}, 170'(p), 170'(e.pass));
    cmp({e.name, ".err_cnt"}, 170'(ec), 170'(e.err));
    cmp({e.name, ".fail_idx"}, 170'(fi), 170'(e.fidx));
    cmp({e.name, ".fail_got"}, 170'(fg), 170'(e.fgot));
    cmp({e.name, ".dut_in"}, di, e.din);
    cmp({e.name, ".busy_cycles"}, 170'(cy), 170'(e.cyc));
  endtask
  initial begin
    cyc_d = 0;
    dq_d = 0;
    forever begin
      @(negedge clk);
      if (busy) cyc_d++;
      else if (done && !dq_d) begin
        if (qd.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL dut.done: got unexpected done want queued result");
        end else verify(qd.pop_front(), pass, err_cnt, fail_idx, fail_got, dut_in, cyc_d);
        cyc_d = 0;
      end else if (!done) cyc_d = 0;
      dq_d = done;
    end
  end
  initial begin
    cyc_c = 0;
    dq_c = 0;
    forever begin
      @(negedge clk);
      if (busy_c) cyc_c++;
      else if (done_c && !dq_c) begin
        if (qc.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL dut_c.done: got unexpected done want queued result");
        end else verify(qc.pop_front(), pass_c, err_cnt_c, fail_idx_c, fail_got_c, dut_in_c, cyc_c);
        cyc_c = 0;
      end else if (!done_c) cyc_c = 0;
      dq_c = done_c;
    end
  end
  task automatic wr(input int a, input logic [169:0] vin, input logic [70:0] ex, input logic [70:0] mk_);
    @(posedge clk);
    #1;
    wr_en = 1;
    wr_addr = 10'(a);
    wr_in = vin;
    wr_exp = ex;
    wr_mask = mk_;
    @(posedge clk);
    #1;
    wr_en = 0;
  endtask
  task automatic go(input bit c, input int n);
    @(posedge clk);
    #1;
    num_vec = 11'(n);
    if (c) start_c = 1;
    else start = 1;
    @(posedge clk);
    #1;
    start = 0;
    start_c = 0;
  endtask
  task automatic wait_done(input bit c, input int lim);
    int k = 0;
    while (!(c ? done_c : done) && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (k >= lim) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got no done after %0d cycles want done", lim);
    end
    @(negedge clk);
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1;
    {wr_en, start, start_c, hold, abort} = '0;
    wr_addr = '0;
    wr_in = '0;
    wr_exp = '0;
    wr_mask = '0;
    num_vec = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    cmp("rst.busy", 170'(busy), 170'(0));
    cmp("rst.done", 170'(done), 170'(0));
    cmp("rst.pass", 170'(pass), 170'(0));
    cmp("rst.dut_in", dut_in, 170'(0));
    cmp("rst.err_cnt", 170'(err_cnt), 170'(0));
    for (int i = 0; i < 4; i++) wr(i, mk(i), f(mk(i)), '1);
    qd.push_back('{"basic", 1'b1, 16'd0, 10'd0, 71'd0, mk(3), 6});
    go(0, 4);
    go(0, 0);
    wait_done(0, 50);
    wr(2, mk(2), f(mk(2)) ^ 71'd1, '1);
    qd.push_back('{"stop", 1'b0, 16'd1, 10'd2, f(mk(2)), mk(2), 5});
    go(0, 4);
    wait_done(0, 50);
    wr(2, mk(2), f(mk(2)) ^ 71'd1, ~71'd1);
    qd.push_back('{"masked", 1'b1, 16'd0, 10'd0, 71'd0, mk(3), 6});
    go(0, 4);
    wait_done(0, 50);
    wr(2, mk(2), f(mk(2)), '1);
    wr(1, mk(1), f(mk(1)) ^ (71'd1 << 5), '1);
    wr(3, mk(3), f(mk(3)) ^ {1'b1, 70'd0}, '1);
    qc.push_back('{"count", 1'b0, 16'd2, 10'd1, f(mk(1)), mk(3), 6});
    go(1, 4);
    wait_done(1, 50);
    wr(1, mk(1), f(mk(1)), '1);
    wr(3, mk(3), f(mk(3)), '1);
    qd.push_back('{"hold", 1'b1, 16'd0, 10'd0, 71'd0, mk(3), 9});
    go(0, 4);
    repeat (2) @(posedge clk);
    #1 hold = 1;
    repeat (3) begin
      @(negedge clk);
      cmp("hold.dut_in", dut_in, mk(0));
    end
    @(posedge clk);
    #1 hold = 0;
    wait_done(0, 50);
    go(0, 4);
    repeat (2) @(posedge clk);
    #1 abort = 1;
    @(posedge clk);
    #1 abort = 0;
    @(negedge clk);
    cmp("abort.busy", 170'(busy), 170'(0));
    cmp("abort.done", 170'(done), 170'(0));
    cmp("abort.dut_in", dut_in, 170'(0));
    qd.push_back('{"zero", 1'b1, 16'd0, 10'd0, 71'd0, 170'd0, 0});
    go(0, 0);
    cmp("zero.done", 170'(done), 170'(1));
    wait_done(0, 5);
    for (int i = 0; i < 1024; i++) wr(i, mk(i), '0, '0);
    qd.push_back('{"clamp", 1'b1, 16'd0, 10'd0, 71'd0, mk(1023), 1026});
    go(0, 2047);
    wait_done(0, 1200);
    repeat (3) @(negedge clk);
    cmp("qd.left", 170'(qd.size()), 170'(0));
    cmp("qc.left", 170'(qc.size()), 170'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
